// File: rtl/spi_pixel_sequencer.sv
// SPI byte-stream to pixel-buffer sequencer: parses 0xA5/len/GRB frames and 0x5A replays.
// Define SPI_SEQ_CHECKSUM_EN to require a trailing XOR checksum byte after the last pixel.
module spi_pixel_sequencer #(
    parameter int MAX_PIX = 256,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ssel_active,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          tx_busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [23:0]   wr_data,
    output logic          tx_start,
    output logic [AW:0]   tx_count,
    output logic          frame_done,
    output logic [7:0]    err_cnt
);

    typedef enum logic [2:0] {
        IDLE, LEN, PIX_G, PIX_R, PIX_B, CHK, SHOW, DRAIN
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] index, index_n;
    logic [AW-1:0] last_idx, last_idx_n;
    logic [AW:0]   n_pix, n_pix_n;
    logic [7:0]    g_byte, g_n;
    logic [7:0]    r_byte, r_n;
    logic [7:0]    chk, chk_n;
    logic          wr_en_n, tx_start_n, frame_done_n;
    logic [AW-1:0] wr_addr_n;
    logic [23:0]   wr_data_n;
    logic [AW:0]   tx_count_n;
    logic [7:0]    err_cnt_n;
    logic          err_inc;

    always_comb begin
        state_n      = state;
        index_n      = index;
        last_idx_n   = last_idx;
        n_pix_n      = n_pix;
        g_n          = g_byte;
        r_n          = r_byte;
        chk_n        = chk;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        tx_start_n   = 1'b0;
        frame_done_n = 1'b0;
        tx_count_n   = tx_count;
        err_inc      = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'hA5) begin
                        state_n = LEN;
                    end else if (rx_data == 8'h5A) begin
                        n_pix_n = tx_count;
                        state_n = SHOW;
                    end else begin
                        err_inc = 1'b1;
                        state_n = DRAIN;
                    end
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (int'(rx_data) >= MAX_PIX) begin
                        err_inc = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        last_idx_n = AW'(rx_data);
                        n_pix_n    = (AW+1)'(rx_data) + (AW+1)'(1);
                        index_n    = '0;
                        chk_n      = rx_data;
                        state_n    = PIX_G;
                    end
                end
            end
            PIX_G: begin
                if (rx_valid) begin
                    g_n     = rx_data;
                    chk_n   = chk ^ rx_data;
                    state_n = PIX_R;
                end
            end
            PIX_R: begin
                if (rx_valid) begin
                    r_n     = rx_data;
                    chk_n   = chk ^ rx_data;
                    state_n = PIX_B;
                end
            end
            PIX_B: begin
                if (rx_valid) begin
                    chk_n     = chk ^ rx_data;
                    wr_en_n   = 1'b1;
                    wr_addr_n = index;
                    wr_data_n = {g_byte, r_byte, rx_data};
                    if (index == last_idx) begin
`ifdef SPI_SEQ_CHECKSUM_EN
                        state_n = CHK;
`else
                        state_n = SHOW;
`endif
                    end else begin
                        index_n = index + AW'(1);
                        state_n = PIX_G;
                    end
                end
            end
            CHK: begin
`ifdef SPI_SEQ_CHECKSUM_EN
                if (rx_valid) begin
                    if (rx_data == chk) begin
                        state_n = SHOW;
                    end else begin
                        err_inc = 1'b1;
                        state_n = DRAIN;
                    end
                end
`else
                state_n = IDLE;
`endif
            end
            SHOW: begin
                // Registered tx_start lands at least one cycle after the final wr_en.
                if (!tx_busy) begin
                    tx_start_n   = 1'b1;
                    frame_done_n = 1'b1;
                    tx_count_n   = n_pix;
                    state_n      = DRAIN;
                end
            end
            DRAIN: begin
                if (!ssel_active) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Chip-select loss mid-frame overrides whatever the byte decided, after it was consumed.
        if (!ssel_active && (state inside {LEN, PIX_G, PIX_R, PIX_B, CHK})) begin
            state_n = IDLE;
            err_inc = 1'b1;
        end

        err_cnt_n = (err_inc && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            index      <= '0;
            last_idx   <= '0;
            n_pix      <= '0;
            g_byte     <= '0;
            r_byte     <= '0;
            chk        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            tx_count   <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            index      <= index_n;
            last_idx   <= last_idx_n;
            n_pix      <= n_pix_n;
            g_byte     <= g_n;
            r_byte     <= r_n;
            chk        <= chk_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            tx_start   <= tx_start_n;
            frame_done <= frame_done_n;
            tx_count   <= tx_count_n;
            err_cnt    <= err_cnt_n;
        end
    end

endmodule

// File: tb/tb_spi_pixel_sequencer.sv
// Directed self-checking bench for spi_pixel_sequencer (MAX_PIX=4 to reach the length limit).
// Checksum frames are exercised only when SPI_SEQ_CHECKSUM_EN is defined.
module tb_spi_pixel_sequencer;

    localparam int MAX_PIX = 4;
    localparam int AW      = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ssel_active;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          tx_busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          tx_start;
    logic [AW:0]   tx_count;
    logic          frame_done;
    logic [7:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    int cycleNum = 0, wrTotal = 0, txTotal = 0, doneTotal = 0;
    int lastWrCycle = 0, lastTxCycle = 0;
    logic [AW-1:0] wrAddrLog [0:63];
    logic [23:0]   wrDataLog [0:63];
    int wrBase, txBase, doneBase;
    int expErr;
    logic [7:0] runXor;

    spi_pixel_sequencer #(.MAX_PIX(MAX_PIX), .AW(AW)) dut (
        .clk(clk), .reset(reset), .ssel_active(ssel_active),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_start(tx_start), .tx_count(tx_count), .frame_done(frame_done),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Event log sampled on the falling edge, between registered output updates.
    always @(negedge clk) begin
        cycleNum++;
        if (wr_en) begin
            wrAddrLog[wrTotal % 64] = wr_addr;
            wrDataLog[wrTotal % 64] = wr_data;
            wrTotal++;
            lastWrCycle = cycleNum;
        end
        if (tx_start) begin
            txTotal++;
            lastTxCycle = cycleNum;
        end
        if (frame_done) doneTotal++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic dropSsel = 1'b0);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (dropSsel) ssel_active = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic startFrame(input logic [7:0] lenByte);
        applyStimulus(8'hA5);
        runXor = lenByte;
        applyStimulus(lenByte);
    endtask

    task automatic pixelByte(input logic [7:0] b);
        runXor = runXor ^ b;
        applyStimulus(b);
    endtask

    task automatic finishFrame();
`ifdef SPI_SEQ_CHECKSUM_EN
        applyStimulus(runXor);
`endif
    endtask

    task automatic endTransfer();
        waitCycles(1);
        @(negedge clk) ssel_active = 1'b0;
        @(negedge clk);
        @(negedge clk) ssel_active = 1'b1;
        #1;
    endtask

    task automatic waitTx(input int base, input int limit);
        int k = 0;
        while (txTotal == base && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    task automatic snapshot();
        wrBase   = wrTotal;
        txBase   = txTotal;
        doneBase = doneTotal;
    endtask

    initial begin
        reset = 1'b1; ssel_active = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0;
        expErr = 0;
        runXor = 8'h00;
        waitCycles(3);
        @(negedge clk) reset = 1'b0;
        waitCycles(1);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_tx_count", 32'(tx_count), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);

        // Single-pixel frame
        ssel_active = 1'b1;
        snapshot();
        startFrame(8'h00);
        pixelByte(8'h10); pixelByte(8'h20); pixelByte(8'h30);
        finishFrame();
        waitTx(txBase, 20);
        waitCycles(1);
        checkOutput("f1_writes", 32'(wrTotal - wrBase), 32'd1);
        checkOutput("f1_addr", 32'(wrAddrLog[wrBase % 64]), 32'd0);
        checkOutput("f1_data", 32'(wrDataLog[wrBase % 64]), 32'h102030);
        checkOutput("f1_tx_start", 32'(txTotal - txBase), 32'd1);
        checkOutput("f1_tx_count", 32'(tx_count), 32'd1);
        checkOutput("f1_frame_done", 32'(doneTotal - doneBase), 32'd1);
        checkOutput("f1_tx_after_wr", 32'(lastTxCycle > lastWrCycle), 32'd1);
        checkOutput("f1_err", 32'(err_cnt), 32'(expErr));
        endTransfer();

        // Three pixels, transmitter busy holds off tx_start
        snapshot();
        tx_busy = 1'b1;
        startFrame(8'h02);
        for (int i = 1; i <= 9; i++) pixelByte(8'(i));
        finishFrame();
        waitCycles(8);
        checkOutput("f3_busy_hold", 32'(txTotal - txBase), 32'd0);
        checkOutput("f3_writes", 32'(wrTotal - wrBase), 32'd3);
        tx_busy = 1'b0;
        waitTx(txBase, 20);
        waitCycles(1);
        checkOutput("f3_tx_start", 32'(txTotal - txBase), 32'd1);
        checkOutput("f3_tx_count", 32'(tx_count), 32'd3);
        checkOutput("f3_addr0", 32'(wrAddrLog[wrBase % 64]), 32'd0);
        checkOutput("f3_data0", 32'(wrDataLog[wrBase % 64]), 32'h010203);
        checkOutput("f3_addr1", 32'(wrAddrLog[(wrBase + 1) % 64]), 32'd1);
        checkOutput("f3_addr2", 32'(wrAddrLog[(wrBase + 2) % 64]), 32'd2);
        checkOutput("f3_data2", 32'(wrDataLog[(wrBase + 2) % 64]), 32'h070809);
        endTransfer();

        // Chip select drops mid-frame after one pixel
        snapshot();
        startFrame(8'h01);
        pixelByte(8'h11); pixelByte(8'h22); pixelByte(8'h33); pixelByte(8'h44);
        waitCycles(2);
        @(negedge clk) ssel_active = 1'b0;
        waitCycles(2);
        expErr++;
        checkOutput("abort_writes", 32'(wrTotal - wrBase), 32'd1);
        checkOutput("abort_data", 32'(wrDataLog[wrBase % 64]), 32'h112233);
        checkOutput("abort_no_tx", 32'(txTotal - txBase), 32'd0);
        checkOutput("abort_err", 32'(err_cnt), 32'(expErr));
        ssel_active = 1'b1;
        waitCycles(1);

        // Bad command byte, drained traffic, then replay
        snapshot();
        applyStimulus(8'h33);
        waitCycles(1);
        expErr++;
        checkOutput("badcmd_err", 32'(err_cnt), 32'(expErr));
        startFrame(8'h00);
        pixelByte(8'h01); pixelByte(8'h02); pixelByte(8'h03);
        waitCycles(3);
        checkOutput("drain_writes", 32'(wrTotal - wrBase), 32'd0);
        checkOutput("drain_no_tx", 32'(txTotal - txBase), 32'd0);
        endTransfer();
        applyStimulus(8'h5A);
        waitTx(txBase, 20);
        waitCycles(1);
        checkOutput("replay_tx", 32'(txTotal - txBase), 32'd1);
        checkOutput("replay_count", 32'(tx_count), 32'd3);
        checkOutput("replay_done", 32'(doneTotal - doneBase), 32'd1);
        endTransfer();

        // Length limit: N=5 rejected, N=4 accepted
        snapshot();
        startFrame(8'h04);
        waitCycles(1);
        expErr++;
        checkOutput("len_reject_err", 32'(err_cnt), 32'(expErr));
        endTransfer();
        startFrame(8'h03);
        for (int i = 0; i < 12; i++) pixelByte(8'(8'h40 + i));
        finishFrame();
        waitTx(txBase, 20);
        waitCycles(1);
        checkOutput("len_max_writes", 32'(wrTotal - wrBase), 32'd4);
        checkOutput("len_max_addr3", 32'(wrAddrLog[(wrBase + 3) % 64]), 32'd3);
        checkOutput("len_max_data3", 32'(wrDataLog[(wrBase + 3) % 64]), 32'h494A4B);
        checkOutput("len_max_count", 32'(tx_count), 32'd4);
        endTransfer();

        // Byte and chip-select fall in the same cycle
        snapshot();
        startFrame(8'h00);
        applyStimulus(8'hAA, 1'b1);
        waitCycles(2);
        expErr++;
        checkOutput("same_cycle_err", 32'(err_cnt), 32'(expErr));
        checkOutput("same_cycle_writes", 32'(wrTotal - wrBase), 32'd0);
        checkOutput("same_cycle_no_tx", 32'(txTotal - txBase), 32'd0);
        ssel_active = 1'b1;
        waitCycles(1);

        // Chip select loss while waiting in SHOW does not cancel the transmit
        snapshot();
        tx_busy = 1'b1;
        startFrame(8'h00);
        pixelByte(8'h05); pixelByte(8'h06); pixelByte(8'h07);
        finishFrame();
        waitCycles(2);
        applyStimulus(8'hA5);
        @(negedge clk) ssel_active = 1'b0;
        waitCycles(3);
        checkOutput("show_hold", 32'(txTotal - txBase), 32'd0);
        tx_busy = 1'b0;
        waitTx(txBase, 20);
        waitCycles(2);
        checkOutput("show_tx", 32'(txTotal - txBase), 32'd1);
        checkOutput("show_count", 32'(tx_count), 32'd1);
        checkOutput("show_err", 32'(err_cnt), 32'(expErr));
        checkOutput("show_writes", 32'(wrTotal - wrBase), 32'd1);
        ssel_active = 1'b1;
        waitCycles(1);

`ifdef SPI_SEQ_CHECKSUM_EN
        snapshot();
        startFrame(8'h00);
        pixelByte(8'h01); pixelByte(8'h02); pixelByte(8'h03);
        applyStimulus(8'h00);
        waitTx(txBase, 20);
        waitCycles(1);
        checkOutput("chk_good_tx", 32'(txTotal - txBase), 32'd1);
        endTransfer();
        snapshot();
        startFrame(8'h00);
        pixelByte(8'h01); pixelByte(8'h02); pixelByte(8'h03);
        applyStimulus(8'h55);
        waitCycles(4);
        expErr++;
        checkOutput("chk_bad_no_tx", 32'(txTotal - txBase), 32'd0);
        checkOutput("chk_bad_err", 32'(err_cnt), 32'(expErr));
        endTransfer();
`endif

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'h33);
            @(negedge clk) ssel_active = 1'b0;
            @(negedge clk) ssel_active = 1'b1;
        end
        waitCycles(1);
        checkOutput("err_saturate", 32'(err_cnt), 32'hFF);

        // Reset in the middle of a pixel
        snapshot();
        startFrame(8'h01);
        pixelByte(8'h77);
        waitCycles(1);
        @(negedge clk) reset = 1'b1;
        waitCycles(2);
        @(negedge clk) reset = 1'b0;
        waitCycles(3);
        checkOutput("midrst_err", 32'(err_cnt), 32'd0);
        checkOutput("midrst_no_tx", 32'(txTotal - txBase), 32'd0);
        checkOutput("midrst_writes", 32'(wrTotal - wrBase), 32'd0);
        checkOutput("midrst_tx_count", 32'(tx_count), 32'd0);
        applyStimulus(8'h5A);
        waitTx(txBase, 20);
        waitCycles(1);
        checkOutput("midrst_idle_replay", 32'(txTotal - txBase), 32'd1);
        checkOutput("midrst_replay_count", 32'(tx_count), 32'd0);
        checkOutput("midrst_err_after", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
